// File: rtl/hazard_scoreboard_fwd.sv
// hazard_scoreboard_fwd: shadow destination-tag pipeline that produces the ID
// load-use stall and the EX operand-forwarding selects and operands.
module hazard_scoreboard_fwd #(
    parameter int DATA_W     = 8,
    parameter int REG_AW     = 3,
    parameter int MEM_STAGES = 1,
    parameter bit R0_ZERO    = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic                               id_valid_i,
    input  logic [REG_AW-1:0]                  id_rs1_i,
    input  logic [REG_AW-1:0]                  id_rs2_i,
    input  logic                               id_use_rs1_i,
    input  logic                               id_use_rs2_i,
    input  logic [REG_AW-1:0]                  id_rd_i,
    input  logic                               id_regwrite_i,
    input  logic                               id_is_load_i,
    input  logic                               flush_i,
    input  logic [DATA_W-1:0]                  ex_rf_a_i,
    input  logic [DATA_W-1:0]                  ex_rf_b_i,
    input  logic [DATA_W*(MEM_STAGES+2)-1:0]   stage_data_i,
    output logic                               stall_o,
    output logic                               ex_valid_o,
    output logic [DATA_W-1:0]                  ex_opa_o,
    output logic [DATA_W-1:0]                  ex_opb_o,
    output logic [$clog2(MEM_STAGES+3)-1:0]    ex_sel_a_o,
    output logic [$clog2(MEM_STAGES+3)-1:0]    ex_sel_b_o,
    output logic                               fwd_err_o
);
    localparam int K  = MEM_STAGES;
    localparam int NS = K + 3;
    localparam int SW = $clog2(K + 3);

    logic [NS-1:0]             v_q, rw_q, ld_q, v_d;
    logic [NS-1:0][REG_AW-1:0] rd_q;
    logic [REG_AW-1:0]         rs1_q, rs2_q;
    logic                      u1_q, u2_q, err_q, err_d;
    logic                      hz, bad_a, bad_b;

    function automatic logic is_r0(input logic [REG_AW-1:0] r);
        return R0_ZERO && r == '0;
    endfunction

    // Only loads still short of WB can cause a stall
    always_comb begin
        hz = 1'b0;
        for (int p = 0; p < K; p++)
            if (v_q[p] && rw_q[p] && ld_q[p] && !is_r0(rd_q[p]) &&
                ((id_use_rs1_i && id_rs1_i == rd_q[p]) || (id_use_rs2_i && id_rs2_i == rd_q[p])))
                hz = 1'b1;
        stall_o = hz && id_valid_i && !flush_i;
    end

    // Scan oldest to youngest so the youngest match is left standing
    always_comb begin
        ex_sel_a_o = '0;
        ex_sel_b_o = '0;
        ex_opa_o   = ex_rf_a_i;
        ex_opb_o   = ex_rf_b_i;
        bad_a      = 1'b0;
        bad_b      = 1'b0;
        for (int p = NS - 1; p >= 1; p--) begin
            if (v_q[0] && u1_q && !is_r0(rs1_q) && v_q[p] && rw_q[p] && rd_q[p] == rs1_q) begin
                bad_a      = ld_q[p] && p <= K;
                ex_sel_a_o = bad_a ? '0 : SW'(p);
                ex_opa_o   = bad_a ? ex_rf_a_i : stage_data_i[(p-1)*DATA_W +: DATA_W];
            end
            if (v_q[0] && u2_q && !is_r0(rs2_q) && v_q[p] && rw_q[p] && rd_q[p] == rs2_q) begin
                bad_b      = ld_q[p] && p <= K;
                ex_sel_b_o = bad_b ? '0 : SW'(p);
                ex_opb_o   = bad_b ? ex_rf_b_i : stage_data_i[(p-1)*DATA_W +: DATA_W];
            end
        end
    end

    assign v_d        = {v_q[NS-2:0], id_valid_i && !stall_o && !flush_i};
    assign err_d      = err_q || bad_a || bad_b;
    assign ex_valid_o = v_q[0];
    assign fwd_err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            v_q   <= '0;
            err_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            err_q <= err_d;
        end
        rw_q  <= {rw_q[NS-2:0], id_regwrite_i};
        ld_q  <= {ld_q[NS-2:0], id_is_load_i};
        rd_q  <= {rd_q[NS-2:0], id_rd_i};
        rs1_q <= id_rs1_i;
        rs2_q <= id_rs2_i;
        u1_q  <= id_use_rs1_i;
        u2_q  <= id_use_rs2_i;
    end
endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// tb_hazard_scoreboard_fwd: directed scenarios plus randomized traffic against
// an age-based reference model, on k=1, k=2 and R0_ZERO=1 instances.
module tb_hazard_scoreboard_fwd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, id_valid, use1, use2, rw, ld, flush;
    logic [2:0] rs1, rs2, rd;
    logic [7:0] rf_a, rf_b;
    logic [23:0] sd1;
    logic [31:0] sd2;
    logic       stall0, stall1, stall2, exv0, exv1, exv2, err0, err1, err2;
    logic [7:0] opa0, opb0, opa1, opb1, opa2, opb2;
    logic [1:0] sa0, sb0, sa2, sb2;
    logic [2:0] sa1, sb1;
    int errors = 0;
    int checks = 0;

    hazard_scoreboard_fwd #(.DATA_W(8), .REG_AW(3), .MEM_STAGES(1), .R0_ZERO(1'b0)) u0 (
        .clk_i(clk), .reset_ni(reset_n), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(use1), .id_use_rs2_i(use2), .id_rd_i(rd), .id_regwrite_i(rw), .id_is_load_i(ld),
        .flush_i(flush), .ex_rf_a_i(rf_a), .ex_rf_b_i(rf_b), .stage_data_i(sd1), .stall_o(stall0),
        .ex_valid_o(exv0), .ex_opa_o(opa0), .ex_opb_o(opb0), .ex_sel_a_o(sa0), .ex_sel_b_o(sb0), .fwd_err_o(err0));
    hazard_scoreboard_fwd #(.DATA_W(8), .REG_AW(3), .MEM_STAGES(2), .R0_ZERO(1'b0)) u1 (
        .clk_i(clk), .reset_ni(reset_n), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(use1), .id_use_rs2_i(use2), .id_rd_i(rd), .id_regwrite_i(rw), .id_is_load_i(ld),
        .flush_i(flush), .ex_rf_a_i(rf_a), .ex_rf_b_i(rf_b), .stage_data_i(sd2), .stall_o(stall1),
        .ex_valid_o(exv1), .ex_opa_o(opa1), .ex_opb_o(opb1), .ex_sel_a_o(sa1), .ex_sel_b_o(sb1), .fwd_err_o(err1));
    hazard_scoreboard_fwd #(.DATA_W(8), .REG_AW(3), .MEM_STAGES(1), .R0_ZERO(1'b1)) u2 (
        .clk_i(clk), .reset_ni(reset_n), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_use_rs1_i(use1), .id_use_rs2_i(use2), .id_rd_i(rd), .id_regwrite_i(rw), .id_is_load_i(ld),
        .flush_i(flush), .ex_rf_a_i(rf_a), .ex_rf_b_i(rf_b), .stage_data_i(sd1), .stall_o(stall2),
        .ex_valid_o(exv2), .ex_opa_o(opa2), .ex_opb_o(opb2), .ex_sel_a_o(sa2), .ex_sel_b_o(sb2), .fwd_err_o(err2));

    logic       o_st[3], o_ev[3], o_err[3];
    logic [7:0] o_a[3], o_b[3];
    int         o_sa[3], o_sb[3];
    assign o_st[0] = stall0;  assign o_st[1] = stall1;  assign o_st[2] = stall2;
    assign o_ev[0] = exv0;    assign o_ev[1] = exv1;    assign o_ev[2] = exv2;
    assign o_err[0] = err0;   assign o_err[1] = err1;   assign o_err[2] = err2;
    assign o_a[0] = opa0;     assign o_a[1] = opa1;     assign o_a[2] = opa2;
    assign o_b[0] = opb0;     assign o_b[1] = opb1;     assign o_b[2] = opb2;
    assign o_sa[0] = int'(sa0); assign o_sa[1] = int'(sa1); assign o_sa[2] = int'(sa2);
    assign o_sb[0] = int'(sb0); assign o_sb[1] = int'(sb1); assign o_sb[2] = int'(sb2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] r1, input logic uu1, input logic [2:0] r2,
                          input logic uu2, input logic [2:0] d, input logic w, input logic l);
        id_valid = v; rs1 = r1; use1 = uu1; rs2 = r2; use2 = uu2; rd = d; rw = w; ld = l;
    endtask

    task automatic nop();
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        flush = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rf_a = 8'hA5; rf_b = 8'h3C;
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        tick();
        nop();
        #1;
        checks++; if (exv0 !== 1'b1) begin errors++; $display("FAIL pre_reset_ex_valid got=%b exp=1", exv0); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_id(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 1'b0);
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall0); end
        checks++; if (exv0 !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%b exp=0", exv0); end
        checks++; if (sa0 !== 2'd0) begin errors++; $display("FAIL reset_sel_a got=%0d exp=0", sa0); end
        checks++; if (sb0 !== 2'd0) begin errors++; $display("FAIL reset_sel_b got=%0d exp=0", sb0); end
        checks++; if (opa0 !== 8'hA5) begin errors++; $display("FAIL reset_opa got=%h exp=a5", opa0); end
        checks++; if (opb0 !== 8'h3C) begin errors++; $display("FAIL reset_opb got=%h exp=3c", opb0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_fwd_err got=%b exp=0", err0); end
        drain();
    endtask

    task automatic test_alu_chain();
        sd1 = {8'h99, 8'h77, 8'h2A};
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", stall0); end
        tick();
        nop();
        #1;
        checks++; if (exv0 !== 1'b1) begin errors++; $display("FAIL alu_ex_valid got=%b exp=1", exv0); end
        checks++; if (sa0 !== 2'd1) begin errors++; $display("FAIL alu_sel_a got=%0d exp=1", sa0); end
        checks++; if (opa0 !== 8'h2A) begin errors++; $display("FAIL alu_opa got=%h exp=2a", opa0); end
        checks++; if (sb0 !== 2'd0) begin errors++; $display("FAIL alu_sel_b got=%0d exp=0", sb0); end
        drain();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        tick();
        set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        tick();
        nop();
        #1;
        checks++; if (sa0 !== 2'd3) begin errors++; $display("FAIL alu_rfd_sel_a got=%0d exp=3", sa0); end
        checks++; if (opa0 !== 8'h99) begin errors++; $display("FAIL alu_rfd_opa got=%h exp=99", opa0); end
        drain();
    endtask

    task automatic test_load_use_k1();
        int n;
        sd1 = {8'h01, 8'h5C, 8'h02};
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        #1;
        n = 0;
        while (stall0 === 1'b1 && n < 10) begin n++; tick(); end
        checks++; if (n !== 1) begin errors++; $display("FAIL ld_k1_stall_cycles got=%0d exp=1", n); end
        tick();
        nop();
        #1;
        checks++; if (exv0 !== 1'b1) begin errors++; $display("FAIL ld_k1_ex_valid got=%b exp=1", exv0); end
        checks++; if (sa0 !== 2'd2) begin errors++; $display("FAIL ld_k1_sel_a got=%0d exp=2", sa0); end
        checks++; if (opa0 !== 8'h5C) begin errors++; $display("FAIL ld_k1_opa got=%h exp=5c", opa0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL ld_k1_fwd_err got=%b exp=0", err0); end
        drain();
    endtask

    task automatic test_load_use_k2();
        int n;
        sd2 = {8'h04, 8'h5C, 8'h02, 8'h01};
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        #1;
        n = 0;
        while (stall1 === 1'b1 && n < 10) begin n++; tick(); end
        checks++; if (n !== 2) begin errors++; $display("FAIL ld_k2_stall_cycles got=%0d exp=2", n); end
        tick();
        nop();
        #1;
        checks++; if (sa1 !== 3'd3) begin errors++; $display("FAIL ld_k2_sel_a got=%0d exp=3", sa1); end
        checks++; if (opa1 !== 8'h5C) begin errors++; $display("FAIL ld_k2_opa got=%h exp=5c", opa1); end
        drain();
    endtask

    task automatic test_priority();
        sd1 = {8'h33, 8'h22, 8'h11};
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        tick();
        tick();
        set_id(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b0);
        tick();
        nop();
        #1;
        checks++; if (sa0 !== 2'd1) begin errors++; $display("FAIL prio_sel_a got=%0d exp=1", sa0); end
        checks++; if (sb0 !== 2'd1) begin errors++; $display("FAIL prio_sel_b got=%0d exp=1", sb0); end
        checks++; if (opa0 !== 8'h11) begin errors++; $display("FAIL prio_opa got=%h exp=11", opa0); end
        checks++; if (opb0 !== 8'h11) begin errors++; $display("FAIL prio_opb got=%h exp=11", opb0); end
        drain();
    endtask

    task automatic test_r0();
        rf_a = 8'h6E;
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        #1;
        checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL r0z_stall got=%b exp=0", stall2); end
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL r0_plain_stall got=%b exp=1", stall0); end
        tick();
        checks++; if (exv2 !== 1'b1) begin errors++; $display("FAIL r0z_ex_valid got=%b exp=1", exv2); end
        checks++; if (sa2 !== 2'd0) begin errors++; $display("FAIL r0z_sel_a got=%0d exp=0", sa2); end
        checks++; if (opa2 !== 8'h6E) begin errors++; $display("FAIL r0z_opa got=%h exp=6e", opa2); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL r0_plain_stall_end got=%b exp=0", stall0); end
        tick();
        nop();
        #1;
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL r0z_fwd_err got=%b exp=0", err2); end
        checks++; if (sa0 !== 2'd2) begin errors++; $display("FAIL r0_plain_sel_a got=%0d exp=2", sa0); end
        drain();
    endtask

    task automatic test_flush();
        set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall0); end
        tick();
        flush = 1'b0;
        nop();
        #1;
        checks++; if (exv0 !== 1'b0) begin errors++; $display("FAIL flush_ex_valid got=%b exp=0", exv0); end
        tick();
        checks++; if (exv0 !== 1'b0) begin errors++; $display("FAIL flush_ex_valid_late got=%b exp=0", exv0); end
        drain();
    endtask

    function automatic logic [7:0] slice(input int i, input int a);
        return (i == 1) ? sd2[(a-1)*8 +: 8] : sd1[(a-1)*8 +: 8];
    endfunction

    // Model: per instance, in-flight instructions indexed by age since issue
    task automatic test_random();
        bit         mv[3][5], mrw[3][5], mld[3][5], eu1[3], eu2[3], merr[3], iss[3], berr[3];
        logic [2:0] mrd[3][5], ers1[3], ers2[3];
        int         ks[3];
        bit         r0s[3];
        ks = '{1, 2, 1};
        r0s = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            merr[i] = 1'b0;
            for (int a = 0; a < 5; a++) mv[i][a] = 1'b0;
        end
        nop();
        flush = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            id_valid = $urandom_range(0, 3) != 0;
            rs1 = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom);
            use1 = 1'($urandom); use2 = 1'($urandom);
            rw = $urandom_range(0, 4) != 0; ld = $urandom_range(0, 2) == 0;
            flush = $urandom_range(0, 9) == 0;
            rf_a = 8'($urandom); rf_b = 8'($urandom);
            sd1 = 24'($urandom); sd2 = $urandom;
            reset_n = $urandom_range(0, 49) != 0;
            #1;
            for (int i = 0; i < 3; i++) begin
                int   k, ya, yb, esa, esb;
                bit   hz, est, bada, badb;
                logic [7:0] ea, eb;
                k = ks[i];
                hz = 1'b0;
                for (int a = 0; a < k; a++)
                    if (mv[i][a] && mrw[i][a] && mld[i][a] && !(r0s[i] && mrd[i][a] == 3'd0) &&
                        ((use1 && rs1 == mrd[i][a]) || (use2 && rs2 == mrd[i][a])))
                        hz = 1'b1;
                est = hz && id_valid && !flush;
                ya = 0; yb = 0;
                for (int a = 1; a <= k + 2; a++) begin
                    if (ya == 0 && mv[i][a] && mrw[i][a] && mrd[i][a] == ers1[i]) ya = a;
                    if (yb == 0 && mv[i][a] && mrw[i][a] && mrd[i][a] == ers2[i]) yb = a;
                end
                if (!mv[i][0] || !eu1[i] || (r0s[i] && ers1[i] == 3'd0)) ya = 0;
                if (!mv[i][0] || !eu2[i] || (r0s[i] && ers2[i] == 3'd0)) yb = 0;
                bada = ya > 0 && mld[i][ya] && ya <= k;
                badb = yb > 0 && mld[i][yb] && yb <= k;
                esa = bada ? 0 : ya;
                esb = badb ? 0 : yb;
                ea = (esa == 0) ? rf_a : slice(i, esa);
                eb = (esb == 0) ? rf_b : slice(i, esb);
                checks++; if (o_st[i] !== est) begin errors++; $display("FAIL rnd_stall inst=%0d cyc=%0d got=%b exp=%b", i, c, o_st[i], est); end
                checks++; if (o_ev[i] !== mv[i][0]) begin errors++; $display("FAIL rnd_ex_valid inst=%0d cyc=%0d got=%b exp=%b", i, c, o_ev[i], mv[i][0]); end
                checks++; if (o_sa[i] !== esa) begin errors++; $display("FAIL rnd_sel_a inst=%0d cyc=%0d got=%0d exp=%0d", i, c, o_sa[i], esa); end
                checks++; if (o_sb[i] !== esb) begin errors++; $display("FAIL rnd_sel_b inst=%0d cyc=%0d got=%0d exp=%0d", i, c, o_sb[i], esb); end
                checks++; if (o_a[i] !== ea) begin errors++; $display("FAIL rnd_opa inst=%0d cyc=%0d got=%h exp=%h", i, c, o_a[i], ea); end
                checks++; if (o_b[i] !== eb) begin errors++; $display("FAIL rnd_opb inst=%0d cyc=%0d got=%h exp=%h", i, c, o_b[i], eb); end
                checks++; if (o_err[i] !== merr[i]) begin errors++; $display("FAIL rnd_fwd_err inst=%0d cyc=%0d got=%b exp=%b", i, c, o_err[i], merr[i]); end
                iss[i] = id_valid && !est && !flush;
                berr[i] = bada || badb;
            end
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                for (int a = ks[i] + 2; a >= 1; a--) begin
                    mv[i][a] = mv[i][a-1]; mrw[i][a] = mrw[i][a-1];
                    mld[i][a] = mld[i][a-1]; mrd[i][a] = mrd[i][a-1];
                end
                mv[i][0] = iss[i]; mrw[i][0] = rw; mld[i][0] = ld; mrd[i][0] = rd;
                ers1[i] = rs1; ers2[i] = rs2; eu1[i] = use1; eu2[i] = use2;
                merr[i] = merr[i] || berr[i];
                if (!reset_n) begin
                    merr[i] = 1'b0;
                    for (int a = 0; a < 5; a++) mv[i][a] = 1'b0;
                end
            end
            #1;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        rf_a = '0; rf_b = '0; sd1 = '0; sd2 = '0;
        nop();
        tick();
        tick();
        reset_n = 1'b1;
        test_reset();
        test_alu_chain();
        test_load_use_k1();
        test_load_use_k2();
        test_priority();
        test_r0();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
